cond_unit: RTL

- Conditional-execution stage directly downstream of main_decoder in the single-cycle ARM control unit.
- Consumes the decoder's raw write/branch intents (PCS, RegW, MemW, NoWrite, FlagW) and the ALU's NZCV flags.
- Holds the architectural NZCV flag register.
- Evaluates the instruction's 4-bit Cond field against the stored flags. Drives the gated PCSrc, RegWrite and MemWrite to the datapath.

---
 rtl/cond_pkg.sv | 33 +++
 rtl/cond_check.sv | 48 ++++
 rtl/cond_unit.sv | 66 ++++++
 3 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: shared types and constants for the conditional-execution stage.
//   cond_e  - the 16 ARM condition codes carried in instruction bits [31:28]
//   flags_t - packed {N,Z,C,V} flag vector
//   FLAG_*  - bit positions of each flag inside flags_t
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational condition evaluator.
// Ports:
//   Cond   in  [3:0] instruction condition field
//   Flags  in  [3:0] stored {N,Z,C,V}
//   CondEx out       1 when the condition passes; reserved code 1111 never passes
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  flags_t     Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = Flags[FLAG_N];
  assign w_z  = Flags[FLAG_Z];
  assign w_c  = Flags[FLAG_C];
  assign w_v  = Flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondEx = 1'b0;
    unique case (cond_e'(Cond))
      COND_EQ: CondEx = w_z;
      COND_NE: CondEx = ~w_z;
      COND_CS: CondEx = w_c;
      COND_CC: CondEx = ~w_c;
      COND_MI: CondEx = w_n;
      COND_PL: CondEx = ~w_n;
      COND_VS: CondEx = w_v;
      COND_VC: CondEx = ~w_v;
      COND_HI: CondEx = w_c & ~w_z;
      COND_LS: CondEx = ~w_c | w_z;
      COND_GE: CondEx = w_ge;
      COND_LT: CondEx = ~w_ge;
      COND_GT: CondEx = ~w_z & w_ge;
      COND_LE: CondEx = w_z | ~w_ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage of the single-cycle ARM control unit.
// Holds the NZCV flag register and gates the decoder's write/branch intents
// with the condition result evaluated against the stored flags.
// Ports:
//   clk, reset  in        rising-edge clock, synchronous active-high reset
//   Cond        in  [3:0] instruction condition field
//   ALUFlags    in  [3:0] {N,Z,C,V} from the ALU
//   FlagW       in  [1:0] flag-write enables: [1] -> N,Z  [0] -> C,V
//   PCS/RegW/MemW in      raw PC / register / memory write requests
//   NoWrite     in        suppresses register write (compare/test ops)
//   PCSrc/RegWrite/MemWrite out  gated requests
//   CondEx      out       condition-passed indicator
//   Flags       out [3:0] stored {N,Z,C,V}
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned FLAGW_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             Cond,
  input  logic [3:0]             ALUFlags,
  input  logic [FLAGW_WIDTH-1:0] FlagW,
  input  logic                   PCS,
  input  logic                   RegW,
  input  logic                   MemW,
  input  logic                   NoWrite,
  output logic                   PCSrc,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   CondEx,
  output logic [3:0]             Flags
);

  logic [1:0] r_flags_nz;
  logic [1:0] r_flags_cv;
  flags_t     w_flags;
  logic       w_cond_ex;

  assign w_flags = {r_flags_nz, r_flags_cv};

  // Condition is judged against the stored flags only, so an S-suffixed
  // instruction's own result becomes visible from the next cycle.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (w_flags),
    .CondEx (w_cond_ex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags_nz <= '0;
      r_flags_cv <= '0;
    end else if (w_cond_ex) begin
      if (FlagW[1]) r_flags_nz <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0]) r_flags_cv <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite = MemW & w_cond_ex;
  assign Flags    = w_flags;

endmodule
